// File: rtl/cellram_arb_pkg.sv
// Shared types and constants for the two-master CellRAM Wishbone arbiter.
package cellram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/cellram_arb_wdt.sv
// Watchdog counter for the arbiter: cleared on every state change, counts while running.
// Only instantiated when CELLRAM_ARB_TIMEOUT_EN is defined.
module cellram_arb_wdt
    import cellram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [9:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 10'd1;
        end
    end

    // The first running cycle sees count 0, so the Nth running cycle flags expiry.
    assign expired = run && (count == 10'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cellram_wb_arb.sv
// Two-master round-robin Wishbone arbiter in front of a single CellRAM controller.
// Optional watchdog abort enabled by defining CELLRAM_ARB_TIMEOUT_EN.
module cellram_wb_arb
    import cellram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  gnt_o
);

    arb_state_t state, state_next;
    logic       owner, owner_next;
    logic       last_grant, last_grant_next;
    logic       req0, req1;
    logic       term;
    logic       owner_cyc, owner_stb;
    logic       wdt_expired;
    logic       wdt_abort;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign term      = s_ack_i | s_err_i | s_rty_i;
    assign owner_cyc = (owner == M1) ? m1_cyc_i : m0_cyc_i;
    assign owner_stb = (owner == M1) ? m1_stb_i : m0_stb_i;
    // A slave termination in the same cycle as expiry wins over the abort.
    assign wdt_abort = (state == BUSY) && wdt_expired && !term;

`ifdef CELLRAM_ARB_TIMEOUT_EN
    cellram_arb_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (state_next != state),
        .run     (state != IDLE),
        .expired (wdt_expired)
    );
`else
    logic [9:0] unused_timeout;
    assign unused_timeout = 10'(TIMEOUT_CYCLES);
    assign wdt_expired    = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            owner      <= M0;
            last_grant <= M1;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = BUSY;
                    // On a tie the master that did not finish last goes first.
                    owner_next = (req0 && req1) ? !last_grant : req1;
                end
            end
            BUSY: begin
                if (term) begin
                    state_next      = IDLE;
                    last_grant_next = owner;
                end else if (wdt_expired || !owner_cyc) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (term || wdt_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        gnt_o    = 2'b00;
        if (state == BUSY) begin
            s_adr_o = (owner == M1) ? m1_adr_i : m0_adr_i;
            s_dat_o = (owner == M1) ? m1_dat_i : m0_dat_i;
            s_sel_o = (owner == M1) ? m1_sel_i : m0_sel_i;
            s_we_o  = (owner == M1) ? m1_we_i  : m0_we_i;
            s_cyc_o = owner_cyc && !wdt_abort;
            s_stb_o = owner_stb && !wdt_abort;
            if (owner == M1) begin
                gnt_o    = 2'b10;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || wdt_abort;
                m1_rty_o = s_rty_i;
            end else begin
                gnt_o    = 2'b01;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || wdt_abort;
                m0_rty_o = s_rty_i;
            end
        end
    end

endmodule

// File: tb/tb_cellram_wb_arb.sv
// Directed self-checking bench for cellram_wb_arb; the timeout section follows
// whether CELLRAM_ARB_TIMEOUT_EN is defined for the build.
module tb_cellram_wb_arb;

    logic        clock;
    logic        reset;

    logic [31:0] m0_adr, m0_wdat, m0_rdat;
    logic [3:0]  m0_sel;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err, m0_rty;
    logic [31:0] m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m1_sel;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err, m1_rty;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_we, s_stb, s_cyc, s_ack, s_err, s_rty;
    logic [1:0]  gnt;

    int checks   = 0;
    int failures = 0;

    cellram_wb_arb #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i (clock),
        .wb_rst_i (reset),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_wdat),
        .m0_sel_i (m0_sel),
        .m0_we_i  (m0_we),
        .m0_stb_i (m0_stb),
        .m0_cyc_i (m0_cyc),
        .m0_dat_o (m0_rdat),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m0_rty_o (m0_rty),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_wdat),
        .m1_sel_i (m1_sel),
        .m1_we_i  (m1_we),
        .m1_stb_i (m1_stb),
        .m1_cyc_i (m1_cyc),
        .m1_dat_o (m1_rdat),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m1_rty_o (m1_rty),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_sel_o  (s_sel),
        .s_we_o   (s_we),
        .s_stb_o  (s_stb),
        .s_cyc_o  (s_cyc),
        .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .s_rty_i  (s_rty),
        .gnt_o    (gnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (idx == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = sel;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = sel;
        end
        #1;
    endtask

    task automatic slaveRespond(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
        s_ack  = ack;
        s_err  = err;
        s_rty  = rty;
        s_rdat = dat;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
        s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (2) tick();

        // Outputs held at zero while reset is asserted, whatever the inputs do.
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000, 32'h5555_5555, 4'hF);
        slaveRespond(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        checkOutput("rst_gnt",    32'(gnt),   32'd0);
        checkOutput("rst_s_cyc",  32'(s_cyc), 32'd0);
        checkOutput("rst_s_stb",  32'(s_stb), 32'd0);
        checkOutput("rst_s_we",   32'(s_we),  32'd0);
        checkOutput("rst_s_adr",  s_adr,      32'd0);
        checkOutput("rst_s_dat",  s_wdat,     32'd0);
        checkOutput("rst_s_sel",  32'(s_sel), 32'd0);
        checkOutput("rst_m0_ack", 32'(m0_ack), 32'd0);
        checkOutput("rst_m0_dat", m0_rdat,    32'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        tick();

        // Single m0 read, slave acks on the 9th busy cycle.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'hF);
        checkOutput("a_idle_gnt", 32'(gnt), 32'd0);
        tick();
        checkOutput("a_gnt",   32'(gnt),   32'h1);
        checkOutput("a_s_cyc", 32'(s_cyc), 32'd1);
        checkOutput("a_s_stb", 32'(s_stb), 32'd1);
        checkOutput("a_s_adr", s_adr,      32'h0000_0100);
        checkOutput("a_s_sel", 32'(s_sel), 32'hF);
        checkOutput("a_s_we",  32'(s_we),  32'd0);
        repeat (8) tick();
        checkOutput("a_wait_ack", 32'(m0_ack), 32'd0);
        slaveRespond(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checkOutput("a_m0_ack", 32'(m0_ack), 32'd1);
        checkOutput("a_m0_dat", m0_rdat,     32'hDEAD_BEEF);
        checkOutput("a_m1_ack", 32'(m1_ack), 32'd0);
        checkOutput("a_m1_dat", m1_rdat,     32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("a_end_gnt",   32'(gnt),   32'd0);
        checkOutput("a_end_s_stb", 32'(s_stb), 32'd0);

        // m1 write aborted by dropping cyc; m0 waits pending through DRAIN.
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3);
        tick();
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 4'hF);
        checkOutput("c_gnt",   32'(gnt),   32'h2);
        checkOutput("c_s_we",  32'(s_we),  32'd1);
        checkOutput("c_s_dat", s_wdat,     32'h1234_5678);
        checkOutput("c_s_adr", s_adr,      32'h0000_0200);
        checkOutput("c_s_sel", 32'(s_sel), 32'h3);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        checkOutput("c_drop_s_cyc", 32'(s_cyc), 32'd0);
        checkOutput("c_drop_gnt",   32'(gnt),   32'h2);
        tick();
        checkOutput("c_drain_gnt",   32'(gnt),   32'd0);
        checkOutput("c_drain_s_cyc", 32'(s_cyc), 32'd0);
        checkOutput("c_drain_s_stb", 32'(s_stb), 32'd0);
        repeat (2) tick();
        checkOutput("c_drain_hold_gnt", 32'(gnt), 32'd0);
        slaveRespond(1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);
        checkOutput("c_m1_ack", 32'(m1_ack), 32'd0);
        checkOutput("c_m1_dat", m1_rdat,     32'd0);
        checkOutput("c_m0_ack", 32'(m0_ack), 32'd0);
        tick();
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("c_idle_gnt", 32'(gnt), 32'd0);
        tick();
        checkOutput("c_m0_gnt",   32'(gnt), 32'h1);
        checkOutput("c_m0_s_adr", s_adr,    32'h0000_0300);
        slaveRespond(1'b1, 1'b0, 1'b0, 32'h0000_0011);
        checkOutput("c_m0_ack2", 32'(m0_ack), 32'd1);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of an m1 transfer.
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0077, 4'hF);
        tick();
        checkOutput("d_gnt", 32'(gnt), 32'h2);
        reset = 1'b1;
        slaveRespond(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        checkOutput("d_rst_gnt",    32'(gnt),    32'd0);
        checkOutput("d_rst_s_cyc",  32'(s_cyc),  32'd0);
        checkOutput("d_rst_s_stb",  32'(s_stb),  32'd0);
        checkOutput("d_rst_s_we",   32'(s_we),   32'd0);
        checkOutput("d_rst_s_adr",  s_adr,       32'd0);
        checkOutput("d_rst_s_dat",  s_wdat,      32'd0);
        checkOutput("d_rst_m1_ack", 32'(m1_ack), 32'd0);
        checkOutput("d_rst_m1_dat", m1_rdat,     32'd0);
        tick();
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'd0, 4'hF);
        reset = 1'b0;
        #1;

        // Both masters request continuously: grants alternate starting with m0.
        for (int k = 0; k < 4; k++) begin
            logic exp_m1;
            exp_m1 = (k % 2) == 1;
            checkOutput($sformatf("b%0d_gap_s_stb", k), 32'(s_stb), 32'd0);
            tick();
            checkOutput($sformatf("b%0d_gnt", k), 32'(gnt), exp_m1 ? 32'h2 : 32'h1);
            checkOutput($sformatf("b%0d_s_adr", k), s_adr, exp_m1 ? 32'h0000_2000 : 32'h0000_1000);
            slaveRespond(1'b1, 1'b0, 1'b0, 32'h0000_00B0 + 32'(k));
            checkOutput($sformatf("b%0d_owner_ack", k), 32'(exp_m1 ? m1_ack : m0_ack), 32'd1);
            checkOutput($sformatf("b%0d_owner_dat", k), exp_m1 ? m1_rdat : m0_rdat, 32'h0000_00B0 + 32'(k));
            checkOutput($sformatf("b%0d_other_ack", k), 32'(exp_m1 ? m0_ack : m1_ack), 32'd0);
            tick();
            slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        end
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick();

        // Slave never acks.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'd0, 4'hF);
        tick();
        checkOutput("e_gnt", 32'(gnt), 32'h1);
`ifdef CELLRAM_ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            checkOutput($sformatf("e_busy%0d_err", i), 32'(m0_err), 32'd0);
            tick();
        end
        checkOutput("e_abort_err",   32'(m0_err), 32'd1);
        checkOutput("e_abort_m1err", 32'(m1_err), 32'd0);
        checkOutput("e_abort_s_stb", 32'(s_stb),  32'd0);
        checkOutput("e_abort_s_cyc", 32'(s_cyc),  32'd0);
        tick();
        checkOutput("e_drain_err", 32'(m0_err), 32'd0);
        checkOutput("e_drain_gnt", 32'(gnt),    32'd0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            checkOutput($sformatf("e_drain%0d_gnt", i), 32'(gnt), 32'd0);
        end
        tick();
        checkOutput("e_idle_gnt", 32'(gnt), 32'd0);
        tick();
        checkOutput("e_regrant_gnt", 32'(gnt), 32'h1);
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            checkOutput($sformatf("e_hold%0d_gnt", i), 32'(gnt), 32'h1);
            checkOutput($sformatf("e_hold%0d_err", i), 32'(m0_err), 32'd0);
        end
`endif
        slaveRespond(1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("e_s_err_pass", 32'(m0_err), 32'd1);
        checkOutput("e_s_err_ack",  32'(m0_ack), 32'd0);
        checkOutput("e_s_err_m1",   32'(m1_err), 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        slaveRespond(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("e_end_gnt", 32'(gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cellram_wb_arb.md
CELLRAM_WB_ARB -- requirements
Module: cellram_wb_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the cycles in BUSY before a watchdog abort; range 2..1023.
REQ-002 wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-003 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 mN_adr_i/mN_dat_i  in  32 each  master N (N=0,1) address and write data.
REQ-005 mN_sel_i  in  4  byte selects; mN_we_i, mN_stb_i, mN_cyc_i  in  1 each.
REQ-006 mN_dat_o  out  32  read data; mN_ack_o, mN_err_o, mN_rty_o  out  1 each.
REQ-007 s_adr_o/s_dat_o  out  32, s_sel_o  out  4, s_we_o/s_stb_o/s_cyc_o  out  1: shared Wishbone port to the CellRAM controller.
REQ-008 s_dat_i  in  32, s_ack_i/s_err_i/s_rty_i  in  1: slave responses.
REQ-009 gnt_o  out  2  one-hot current owner; 00 when no owner.

Function
REQ-010 reqN SHALL be mN_cyc_i & mN_stb_i.
REQ-011 FSM states SHALL be IDLE, BUSY and DRAIN.
REQ-012 IDLE: s_cyc_o=s_stb_o=0; if any req, register the owner and move to BUSY next edge, so grant latency is 1 cycle.
REQ-013 Tie (both req in IDLE): round-robin, winner = master not in last_grant; a single requester always wins.
REQ-014 BUSY: s_* outputs SHALL mirror the owner's inputs combinationally, and slave dat/ack/err/rty SHALL pass combinationally to the owner only.
REQ-015 The non-owner SHALL see ack/err/rty=0 and dat_o=0.
REQ-016 BUSY, slave ack/err/rty=1: forward it, update last_grant=owner, go IDLE; this guarantees >=1 idle cycle of s_stb_o between transfers.
REQ-017 BUSY, owner drops cyc_i before termination: go DRAIN with s_cyc_o=s_stb_o=0.
REQ-018 DRAIN: wait for slave ack/err/rty without forwarding it, then go IDLE; no new grant while in DRAIN.
REQ-019 Simultaneous slave termination and owner cyc_i drop: REQ-016 applies and the termination is forwarded.
REQ-020 Requests arriving during BUSY/DRAIN SHALL be held pending, not lost, as long as the master keeps cyc/stb asserted.

Reset
REQ-021 On wb_rst_i (any time, including mid-transfer): state=IDLE, gnt_o=00, last_grant=1 (m0 wins the first tie), watchdog count=0.
REQ-022 During reset, all mN_ack/err/rty_o=0, mN_dat_o=0, s_cyc_o=s_stb_o=s_we_o=0, s_adr_o/s_dat_o=0 and s_sel_o=0.

Configuration
REQ-023 Macro CELLRAM_ARB_TIMEOUT_EN.
REQ-024 Defined: a counter clears on entry to BUSY and increments each BUSY cycle. At TIMEOUT_CYCLES with no termination, the arbiter SHALL pulse owner err_o for one cycle, drop s_stb_o/s_cyc_o and enter DRAIN. The same watchdog in DRAIN SHALL force IDLE after TIMEOUT_CYCLES.
REQ-025 Undefined: no counter logic; BUSY and DRAIN wait indefinitely; err_o SHALL only ever be the slave's s_err_i passthrough.

Structure
REQ-026 Package cellram_arb_pkg SHALL hold the state typedef (IDLE/BUSY/DRAIN), the master index constants M0=0/M1=1 and the TIMEOUT_CYCLES default.
REQ-027 Sub-module cellram_arb_wdt (counter plus expiry flag) SHALL be instantiated only under CELLRAM_ARB_TIMEOUT_EN; the round-robin pick SHALL stay inline.

Verification
REQ-028 Single request: m0 read adr 0x0000_0100 sel 1111, slave acks 9 cycles later with 0xDEADBEEF -> m0 gets dat 0xDEADBEEF with ack on the same cycle; m1 ack=0; gnt_o=01 then 00.
REQ-029 Tie fairness: m0 and m1 request continuously for 4 transfers -> grant order m0,m1,m0,m1, with s_stb_o low for >=1 cycle between transfers.
REQ-030 Abort: m1 write grant, m1 drops cyc 2 cycles later, slave acks 3 cycles after that -> no ack to m1, DRAIN until the slave ack, then IDLE; a pending m0 is granted the next cycle.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=16): the slave never acks -> owner err_o=1 on the 16th BUSY cycle, then DRAIN, then IDLE 16 cycles later; with the macro off the arbiter stays in BUSY for 1000 cycles.
REQ-032 Reset mid-transfer: assert wb_rst_i in BUSY -> all outputs zero asynchronously, and after release m0 wins a tie against m1.
